// File: rtl/taillight_input_conditioner_if.sv
// Switch inputs and conditioned outputs of the taillight input conditioner.
// The slave side is the conditioner; the master side drives the raw switches.
interface taillight_input_conditioner_if;
    logic       sw_h;
    logic       sw_l;
    logic       sw_r;
    logic       clk_1hz;
    logic       tick;
    logic       H;
    logic       L;
    logic       R;
    logic [2:0] accepted; // debug view of accepted {h,l,r} before resolution

    modport master (
        output sw_h, sw_l, sw_r,
        input  clk_1hz, tick, H, L, R, accepted
    );

    modport slave (
        input  sw_h, sw_l, sw_r,
        output clk_1hz, tick, H, L, R, accepted
    );
endinterface

// File: rtl/taillight_input_conditioner.sv
// Synchronizes, debounces and priority-resolves hazard/left/right switches and
// produces the slow taillight clock. Debounce included when TAILLIGHT_DEBOUNCE_EN is defined.
module taillight_input_conditioner #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int OUT_HZ          = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                          clk_50mhz,
    input  logic                          rst_n,
    taillight_input_conditioner_if.slave  bus
);
    localparam int HALF = CLK_HZ / (2 * OUT_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [2:0] sync1_q, sync2_q;
    logic [2:0] acc;

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.sw_h, bus.sw_l, bus.sw_r};
            sync2_q <= sync1_q;
        end
    end

`ifdef TAILLIGHT_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [2:0]    acc_q, acc_d;
    logic [DW-1:0] db_cnt_q [3];
    logic [DW-1:0] db_cnt_d [3];

    // A counter only runs while the synchronized input disagrees with the accepted value.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != acc_q[i]) begin
                if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1))
                    acc_d[i] = sync2_q[i];
                else
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            acc_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            acc_q <= acc_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign acc = acc_q;
`else
    assign acc = sync2_q;
`endif

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic [2:0]    hlr_q, hlr_d;
    logic [2:0]    hlr_res;
    logic          wrap;

    // Hazard, or both turn switches at once, lights everything as hazard.
    always_comb begin
        hlr_res = {1'b0, acc[1], acc[0]};
        if (acc[2] || (acc[1] && acc[0]))
            hlr_res = 3'b100;
    end

    always_comb begin
        wrap      = (div_cnt_q == CW'(HALF - 1));
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        clk_d     = wrap ? ~clk_q : clk_q;
        tick_d    = wrap && !clk_q;
        hlr_d     = (wrap && clk_q) ? hlr_res : hlr_q;
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            hlr_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            hlr_q     <= hlr_d;
        end
    end

    assign bus.clk_1hz  = clk_q;
    assign bus.tick     = tick_q;
    assign bus.H        = hlr_q[2];
    assign bus.L        = hlr_q[1];
    assign bus.R        = hlr_q[0];
    assign bus.accepted = acc;
endmodule

// File: tb/tb_taillight_input_conditioner.sv
// Directed bench for taillight_input_conditioner with HALF=10 and DEBOUNCE_CYCLES=4.
module tb_taillight_input_conditioner;
  localparam int DEB = 4;
`ifdef TAILLIGHT_DEBOUNCE_EN
  localparam int LAT = DEB + 2;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst_n;
  int   cyc;
  int   tick_cnt;
  int   checks;
  int   errors;

  taillight_input_conditioner_if bus ();

  taillight_input_conditioner #(
    .CLK_HZ          (20),
    .OUT_HZ          (1),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk_50mhz (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave)
  );

  // clock / reset-relative edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tick === 1'b1) tick_cnt++;
      check("l_r_exclusive", {31'd0, bus.L & bus.R}, 32'd0);
    end
  end

  task automatic go(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc < n) check("go_timeout", cyc, n);
  endtask

  task automatic check_hlr(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, bus.H, bus.L, bus.R}, {29'd0, exp});
  endtask

  initial begin
    cyc = 0;
    tick_cnt = 0;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.sw_h = 1'b0;
    bus.sw_l = 1'b0;
    bus.sw_r = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk", {31'd0, bus.clk_1hz}, 32'd0);
    check("rst_tick", {31'd0, bus.tick}, 32'd0);
    check_hlr("rst_hlr", 3'b000);
    check("rst_acc", {29'd0, bus.accepted}, 32'd0);
    rst_n = 1'b1;

    // divider after release
    go(9);   check("clk_e9", {31'd0, bus.clk_1hz}, 32'd0);
    go(10);  check("clk_e10", {31'd0, bus.clk_1hz}, 32'd1);
             check("tick_e10", {31'd0, bus.tick}, 32'd1);
    go(11);  check("tick_e11", {31'd0, bus.tick}, 32'd0);
    go(19);  check("clk_e19", {31'd0, bus.clk_1hz}, 32'd1);
    go(20);  check("clk_e20", {31'd0, bus.clk_1hz}, 32'd0);
    go(29);  check("tick_cnt_29", tick_cnt, 32'd1);
    go(30);  check("clk_e30", {31'd0, bus.clk_1hz}, 32'd1);
             check_hlr("idle_hlr", 3'b000);
    bus.sw_l = 1'b1;
    go(31);  check("tick_cnt_31", tick_cnt, 32'd2);

    // left switch held
    go(30 + LAT - 1); check("l_acc_early", {29'd0, bus.accepted}, 32'd0);
    go(30 + LAT);     check("l_acc", {29'd0, bus.accepted}, 32'h2);
    go(39);  check_hlr("l_before_fall", 3'b000);
    go(40);  check_hlr("l_at_fall", 3'b010);
    go(59);  check_hlr("l_held", 3'b010);
    go(60);  check_hlr("l_held_60", 3'b010);

`ifdef TAILLIGHT_DEBOUNCE_EN
    // three-cycle glitch on the right switch is rejected
    bus.sw_r = 1'b1;
    go(63);
    bus.sw_r = 1'b0;
    for (int e = 64; e <= 80; e++) begin
      go(e);
      check("glitch_acc_r", {31'd0, bus.accepted[0]}, 32'd0);
    end
    check_hlr("glitch_hlr", 3'b010);
`else
    go(80);
`endif

    // both turn switches -> hazard
    bus.sw_r = 1'b1;
    go(80 + LAT); check("lr_acc", {29'd0, bus.accepted}, 32'h3);
    go(99);  check_hlr("lr_before_fall", 3'b010);
    go(100); check_hlr("lr_hazard", 3'b100);

    // hazard with right switch
    bus.sw_h = 1'b1;
    bus.sw_l = 1'b0;
    go(100 + LAT); check("hr_acc", {29'd0, bus.accepted}, 32'h5);
    go(120); check_hlr("hr_hazard", 3'b100);

    // right only
    bus.sw_h = 1'b0;
    go(120 + LAT); check("r_acc", {29'd0, bus.accepted}, 32'h1);
    go(139); check_hlr("r_before_fall", 3'b100);
    go(140); check_hlr("r_at_fall", 3'b001);

    // left again, then reset mid-period at divider count 5
    bus.sw_l = 1'b1;
    bus.sw_r = 1'b0;
    go(140 + LAT); check("l2_acc", {29'd0, bus.accepted}, 32'h2);
    go(160); check_hlr("l2_at_fall", 3'b010);
    go(165);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_clk", {31'd0, bus.clk_1hz}, 32'd0);
    check("mid_rst_tick", {31'd0, bus.tick}, 32'd0);
    check_hlr("mid_rst_hlr", 3'b000);
    check("mid_rst_acc", {29'd0, bus.accepted}, 32'd0);
    rst_n = 1'b1;
    go(165 + LAT - 1); check("rel_acc_early", {29'd0, bus.accepted}, 32'd0);
    go(165 + LAT);     check("rel_acc", {29'd0, bus.accepted}, 32'h2);
    go(174); check("rel_clk_e9", {31'd0, bus.clk_1hz}, 32'd0);
    go(175); check("rel_clk_e10", {31'd0, bus.clk_1hz}, 32'd1);
             check("rel_tick_e10", {31'd0, bus.tick}, 32'd1);
    go(184); check_hlr("rel_before_fall", 3'b000);
    go(185); check_hlr("rel_at_fall", 3'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
